dlx_ctrl_fsm: RTL and testbench

- Multi-cycle control state machine for the DLX core.
- Sequences the instruction register environment: fetch into IR, decode from OPCODE/ALUF, execute, memory access and write-back.
- Drives all datapath clock enables, mux selects and memory strobes.
- Waits on a memory ACK handshake, with a watchdog so the core cannot hang on the bus.

---
 rtl/dlx_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_dlx_ctrl_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dlx_ctrl_fsm.sv
// dlx_ctrl_fsm -- multi-cycle control FSM for the DLX core.
//
// Sequences fetch / decode / execute / memory / write-back and drives every
// datapath clock enable, mux select and memory strobe. Memory states wait on
// i_ack, and a watchdog sends the core to BUSERR if no ACK arrives in time.
//
// Parameters:
//   ACK_LIMIT  max wait cycles in a memory state before BUSERR (1..255)
//   STATE_W    width of o_state
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_run                 1 allows leaving FETCH, 0 parks in FETCH
//   i_opcode[5:0]         IR[31:26]
//   i_aeqz                A == 0 (branch condition)
//   i_ack                 memory access complete
//   o_ir_ce .. o_mdr_ce   datapath register clock enables
//   o_gpr_we              GPR write enable
//   o_mr, o_mw            memory read / write strobes
//   o_alu_sel[1:0]        00 add, 01 ALUF, 10 ALUFP, 11 test
//   o_s1_sel[1:0]         00 PC, 01 A, 10 B, 11 MDR
//   o_s2_sel[1:0]         00 B, 01 SEXT_IMM, 10 const 0, 11 const 1
//   o_dint_sel            C source: 0 ALU, 1 shifter
//   o_illegal             one-cycle pulse on unknown opcode
//   o_halted              state is HALT or BUSERR
//   o_state               current state encoding

module dlx_ctrl_fsm #(
    parameter int ACK_LIMIT = 255,
    parameter int STATE_W   = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [5:0]         i_opcode,
    input  logic               i_aeqz,
    input  logic               i_ack,
    output logic               o_ir_ce,
    output logic               o_pc_ce,
    output logic               o_a_ce,
    output logic               o_b_ce,
    output logic               o_c_ce,
    output logic               o_mar_ce,
    output logic               o_mdr_ce,
    output logic               o_gpr_we,
    output logic               o_mr,
    output logic               o_mw,
    output logic [1:0]         o_alu_sel,
    output logic [1:0]         o_s1_sel,
    output logic [1:0]         o_s2_sel,
    output logic               o_dint_sel,
    output logic               o_illegal,
    output logic               o_halted,
    output logic [STATE_W-1:0] o_state
);

    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_DECODE      = 5'd1,
        S_ALU         = 5'd2,
        S_ALUI        = 5'd3,
        S_TESTI       = 5'd4,
        S_PALU        = 5'd5,
        S_ADDRCMP     = 5'd6,
        S_LOAD        = 5'd7,
        S_COPYMDR2C   = 5'd8,
        S_COPYGPR2MDR = 5'd9,
        S_STORE       = 5'd10,
        S_WBR         = 5'd11,
        S_WBI         = 5'd12,
        S_BRANCH      = 5'd13,
        S_BTAKEN      = 5'd14,
        S_JR          = 5'd15,
        S_SAVEPC      = 5'd16,
        S_JALR        = 5'd17,
        S_HALT        = 5'd30,
        S_BUSERR      = 5'd31
    } state_t;

    // Timeout fires on the wait cycle that would bring the count to ACK_LIMIT.
    localparam logic [7:0] CNT_LAST = 8'(ACK_LIMIT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic        w_wait;
    logic        w_mr, w_ir_ce;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = 8'd0;
        w_wait      = 1'b0;
        w_ir_ce     = 1'b0;
        w_mr        = 1'b0;
        o_pc_ce     = 1'b0;
        o_a_ce      = 1'b0;
        o_b_ce      = 1'b0;
        o_c_ce      = 1'b0;
        o_mar_ce    = 1'b0;
        o_mdr_ce    = 1'b0;
        o_gpr_we    = 1'b0;
        o_mw        = 1'b0;
        o_alu_sel   = 2'b00;
        o_s1_sel    = 2'b00;
        o_s2_sel    = 2'b00;
        o_dint_sel  = 1'b0;
        o_illegal   = 1'b0;
        o_halted    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // RUN=0 parks with the strobe off; w_wait stays 0 so the
                // watchdog count is cleared while parked.
                if (i_run) begin
                    w_mr    = 1'b1;
                    w_ir_ce = i_ack;
                    if (i_ack) w_next = S_DECODE;
                    else       w_wait = 1'b1;
                end
            end
            S_DECODE: begin
                o_a_ce   = 1'b1;
                o_b_ce   = 1'b1;
                o_pc_ce  = 1'b1;
                o_s2_sel = 2'b11;
                casez (i_opcode)
                    6'b00000?: w_next = S_ALU;
                    6'b001???: w_next = S_ALUI;
                    6'b011???: w_next = S_TESTI;
                    6'b100011,
                    6'b101011: w_next = S_ADDRCMP;
                    6'b00010?: w_next = S_BRANCH;
                    6'b010110: w_next = S_JR;
                    6'b010111: w_next = S_SAVEPC;
                    6'b111111: w_next = S_HALT;
                    6'b111???: w_next = S_PALU;
                    default: begin
                        w_next    = S_FETCH;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            S_ALU, S_PALU: begin
                o_c_ce    = 1'b1;
                o_s1_sel  = 2'b01;
                o_alu_sel = (r_state == S_PALU) ? 2'b10 : 2'b01;
                w_next    = S_WBR;
            end
            S_ALUI, S_TESTI: begin
                o_c_ce    = 1'b1;
                o_s1_sel  = 2'b01;
                o_s2_sel  = 2'b01;
                o_alu_sel = (r_state == S_TESTI) ? 2'b11 : 2'b01;
                w_next    = S_WBI;
            end
            S_WBR, S_WBI: begin
                o_gpr_we = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDRCMP: begin
                o_mar_ce = 1'b1;
                o_s1_sel = 2'b01;
                o_s2_sel = 2'b01;
                // Only 100011 / 101011 get here; bit 3 tells store from load.
                w_next   = i_opcode[3] ? S_COPYGPR2MDR : S_LOAD;
            end
            S_LOAD: begin
                w_mr     = 1'b1;
                o_mdr_ce = i_ack;
                if (i_ack) w_next = S_COPYMDR2C;
                else       w_wait = 1'b1;
            end
            S_COPYMDR2C: begin
                o_c_ce   = 1'b1;
                o_s1_sel = 2'b11;
                o_s2_sel = 2'b10;
                w_next   = S_WBI;
            end
            S_COPYGPR2MDR: begin
                o_mdr_ce = 1'b1;
                o_s1_sel = 2'b10;
                o_s2_sel = 2'b10;
                w_next   = S_STORE;
            end
            S_STORE: begin
                o_mw = 1'b1;
                if (i_ack) w_next = S_FETCH;
                else       w_wait = 1'b1;
            end
            S_BRANCH: begin
                w_next = (i_aeqz ^ i_opcode[0]) ? S_BTAKEN : S_FETCH;
            end
            S_BTAKEN: begin
                o_pc_ce  = 1'b1;
                o_s2_sel = 2'b01;
                w_next   = S_FETCH;
            end
            S_JR: begin
                o_pc_ce  = 1'b1;
                o_s1_sel = 2'b01;
                o_s2_sel = 2'b10;
                w_next   = S_FETCH;
            end
            S_SAVEPC: begin
                o_c_ce   = 1'b1;
                o_s2_sel = 2'b10;
                w_next   = S_JALR;
            end
            S_JALR: begin
                o_pc_ce  = 1'b1;
                o_gpr_we = 1'b1;
                o_s1_sel = 2'b01;
                o_s2_sel = 2'b10;
                w_next   = S_FETCH;
            end
            S_HALT, S_BUSERR: begin
                o_halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Watchdog: a waiting cycle either times out or bumps the count;
        // every other cycle (ACK, state change, parked) leaves it at 0.
        if (w_wait) begin
            if (r_cnt == CNT_LAST) w_next     = S_BUSERR;
            else                   w_cnt_next = r_cnt + 8'd1;
        end
    end

    // FETCH is the reset state and its strobe is input-driven, so gate it
    // with reset to drop the bus request the instant reset asserts.
    assign o_mr    = w_mr    & ~i_rst;
    assign o_ir_ce = w_ir_ce & ~i_rst;
    assign o_state = STATE_W'(r_state);

endmodule

// File: tb/tb_dlx_ctrl_fsm.sv
module tb_dlx_ctrl_fsm;
    localparam int LIMIT = 4;

    logic clk = 1'b0, rst = 1'b1, run = 1'b0, ack = 1'b0, aeqz = 1'b0;
    logic [5:0] op = 6'd0;
    logic ir, pc, a, b, c, mar, mdr, gpr, mr, mw, dint, ill, halted;
    logic [1:0] alu, s1, s2;
    logic [4:0] st;

    always #5 clk = ~clk;

    dlx_ctrl_fsm #(.ACK_LIMIT(LIMIT), .STATE_W(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(op), .i_aeqz(aeqz), .i_ack(ack),
        .o_ir_ce(ir), .o_pc_ce(pc), .o_a_ce(a), .o_b_ce(b), .o_c_ce(c), .o_mar_ce(mar),
        .o_mdr_ce(mdr), .o_gpr_we(gpr), .o_mr(mr), .o_mw(mw), .o_alu_sel(alu),
        .o_s1_sel(s1), .o_s2_sel(s2), .o_dint_sel(dint), .o_illegal(ill),
        .o_halted(halted), .o_state(st)
    );

    // Output vector: {ir,pc,a,b,c,mar,mdr,gpr,mr,mw,alu[1:0],s1[1:0],s2[1:0],dint,ill,halted}
    logic [18:0] got_o;
    assign got_o = {ir, pc, a, b, c, mar, mdr, gpr, mr, mw, alu, s1, s2, dint, ill, halted};

    localparam logic [18:0] IR_  = 19'd1 << 18, PC_  = 19'd1 << 17, A_   = 19'd1 << 16;
    localparam logic [18:0] B_   = 19'd1 << 15, C_   = 19'd1 << 14, MAR_ = 19'd1 << 13;
    localparam logic [18:0] MDR_ = 19'd1 << 12, GPR_ = 19'd1 << 11, MR_  = 19'd1 << 10;
    localparam logic [18:0] MW_  = 19'd1 << 9,  ILL_ = 19'd1 << 1,  HLT_ = 19'd1;

    function automatic logic [18:0] sel(input logic [1:0] al, input logic [1:0] x1, input logic [1:0] x2);
        return {13'd0, al, x1, x2} << 3;
    endfunction

    // Instruction classes from the opcode map
    localparam int K_R = 0, K_I = 1, K_T = 2, K_P = 3, K_LD = 4, K_ST = 5, K_BR = 6,
                   K_JR = 7, K_JALR = 8, K_HLT = 9, K_ILL = 10;

    function automatic int klass(input logic [5:0] o);
        if (o[5:1] == 5'b00000)  return K_R;
        if (o[5:3] == 3'b001)    return K_I;
        if (o[5:3] == 3'b011)    return K_T;
        if (o == 6'b100011)      return K_LD;
        if (o == 6'b101011)      return K_ST;
        if (o[5:1] == 5'b00010)  return K_BR;
        if (o == 6'b010110)      return K_JR;
        if (o == 6'b010111)      return K_JALR;
        if (o == 6'b111111)      return K_HLT;
        if (o[5:3] == 3'b111)    return K_P;
        return K_ILL;
    endfunction

    typedef struct { logic [4:0] st; logic [18:0] o; string tag; } exp_t;
    exp_t q[$];
    exp_t me;
    int vecs = 0, errs = 0;
    int hold_n = 8;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            vecs++;
            if ({st, got_o} !== {me.st, me.o}) begin
                errs++;
                $display("FAIL %s: got state=%0d outs=%05h, want state=%0d outs=%05h",
                         me.tag, st, got_o, me.st, me.o);
            end
        end
    end

    task automatic step(input logic [4:0] s, input logic [18:0] o, input string tag);
        exp_t e;
        e.st = s; e.o = o; e.tag = tag;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        run = 1'b1; ack = 1'b1;      // strobe inputs active: outputs must still be 0
        rst = 1'b1;
        step(5'd0, 19'd0, "reset");
        rst = 1'b0;
    endtask

    task automatic absorb(input logic [4:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'($urandom_range(0, 1)); ack = 1'($urandom_range(0, 1));
            step(s, HLT_, (s == 5'd30) ? "halt" : "buserr");
        end
        reset_pulse();
    endtask

    // Memory phase: ACK arrives after w wait cycles; w >= LIMIT never acks.
    task automatic mem(input logic [4:0] s, input int w, input logic [18:0] base,
                       input logic [18:0] on_ack, input string tag, output bit to);
        to = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            ack = (i == w);
            step(s, base | (ack ? on_ack : 19'd0), tag);
            if (i == w) begin to = 1'b0; break; end
        end
    endtask

    task automatic do_instr(input logic [5:0] o, input logic z, input int wf, input int wm);
        bit to;
        int k;
        k = klass(o);
        op = o; run = 1'b1;
        mem(5'd0, wf, MR_, IR_, "fetch", to);
        if (to) begin absorb(5'd31, 3); return; end
        aeqz = z; ack = 1'($urandom_range(0, 1));
        step(5'd1, PC_ | A_ | B_ | sel(2'b00, 2'b00, 2'b11) | ((k == K_ILL) ? ILL_ : 19'd0), "decode");
        case (k)
            K_R:  begin step(5'd2, C_ | sel(2'b01, 2'b01, 2'b00), "alu");   step(5'd11, GPR_, "wbr"); end
            K_P:  begin step(5'd5, C_ | sel(2'b10, 2'b01, 2'b00), "palu");  step(5'd11, GPR_, "wbr"); end
            K_I:  begin step(5'd3, C_ | sel(2'b01, 2'b01, 2'b01), "alui");  step(5'd12, GPR_, "wbi"); end
            K_T:  begin step(5'd4, C_ | sel(2'b11, 2'b01, 2'b01), "testi"); step(5'd12, GPR_, "wbi"); end
            K_LD: begin
                step(5'd6, MAR_ | sel(2'b00, 2'b01, 2'b01), "addrcmp");
                mem(5'd7, wm, MR_, MDR_, "load", to);
                if (to) begin absorb(5'd31, 3); return; end
                ack = 1'($urandom_range(0, 1));
                step(5'd8, C_ | sel(2'b00, 2'b11, 2'b10), "copymdr2c");
                step(5'd12, GPR_, "wbi");
            end
            K_ST: begin
                step(5'd6, MAR_ | sel(2'b00, 2'b01, 2'b01), "addrcmp");
                step(5'd9, MDR_ | sel(2'b00, 2'b10, 2'b10), "copygpr2mdr");
                mem(5'd10, wm, MW_, 19'd0, "store", to);
                if (to) begin absorb(5'd31, 3); return; end
            end
            K_BR: begin
                step(5'd13, 19'd0, "branch");
                if (z ^ o[0]) step(5'd14, PC_ | sel(2'b00, 2'b00, 2'b01), "btaken");
            end
            K_JR: step(5'd15, PC_ | sel(2'b00, 2'b01, 2'b10), "jr");
            K_JALR: begin
                step(5'd16, C_ | sel(2'b00, 2'b00, 2'b10), "savepc");
                step(5'd17, PC_ | GPR_ | sel(2'b00, 2'b01, 2'b10), "jalr");
            end
            K_HLT: absorb(5'd30, hold_n);
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] o;
        int k, wf, wm;
        bit to;
        @(posedge clk); #1;
        reset_pulse();

        // Parked with RUN=0: no strobe, state holds
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin ack = 1'($urandom_range(0, 1)); step(5'd0, 19'd0, "park"); end

        do_instr(6'b000000, 1'b0, 0, 0);          // R-type 0,1,2,11
        do_instr(6'b100011, 1'b0, 0, 3);          // load, 3 wait cycles
        do_instr(6'b000101, 1'b0, 0, 0);          // BNEZ taken
        do_instr(6'b000101, 1'b1, 0, 0);          // BNEZ not taken
        do_instr(6'b010111, 1'b0, 0, 0);          // JALR
        do_instr(6'b101011, 1'b0, 0, LIMIT);      // store timeout -> BUSERR
        do_instr(6'b101011, 1'b0, 0, LIMIT - 1);  // ACK on last allowed cycle
        do_instr(6'b110000, 1'b0, 0, 0);          // illegal
        hold_n = 100;
        do_instr(6'b111111, 1'b0, 0, 0);          // HALT held
        hold_n = 8;

        // Reset asserted mid-LOAD
        op = 6'b100011; run = 1'b1;
        mem(5'd0, 0, MR_, IR_, "fetch", to);
        step(5'd1, PC_ | A_ | B_ | sel(2'b00, 2'b00, 2'b11), "decode");
        step(5'd6, MAR_ | sel(2'b00, 2'b01, 2'b01), "addrcmp");
        ack = 1'b0;
        step(5'd7, MR_, "load");
        reset_pulse();

        // RUN=0 clears the fetch watchdog
        op = 6'b000000; run = 1'b1; ack = 1'b0;
        step(5'd0, MR_, "fetch");
        step(5'd0, MR_, "fetch");
        run = 1'b0;
        step(5'd0, 19'd0, "park");
        do_instr(6'b000000, 1'b0, LIMIT - 1, 0);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                run = 1'b0;
                for (int i = 0; i < 2; i++) begin ack = 1'($urandom_range(0, 1)); step(5'd0, 19'd0, "park"); end
            end
            o = 6'($urandom_range(0, 63));
            k = klass(o);
            case ($urandom_range(0, 5))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = {5'b00010, 1'($urandom_range(0, 1))};
                default: ;
            endcase
            k = klass(o);
            if (k == K_HLT && $urandom_range(0, 3) != 0) o = 6'b000001;
            wf = ($urandom_range(0, 19) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
            wm = ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
            do_instr(o, 1'($urandom_range(0, 1)), wf, wm);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
